fetch_refill_router: RTL and testbench
======================================

// Module: fetch_refill_router
// PURPOSE
// - Routes instruction-cache refill requests to one of NUM_TGT backing responders, for example bootrom or L2 model.
// - Each target owns an address window; the router collects that target's data beats into a full cache line.
// - Returns the line to the fetch side with a one-cycle valid pulse.
// - A watchdog turns a silent target into an error response instead of a hung simulation.
// - Sits between the core tile's refill port and the simulation memory models in the top-level harness.
// PARAMETERS
// - NUM_TGT        2            number of targets (1..8)
// - ADDR_W         40           physical address width
// - LINE_W         256          cache line width returned to fetch
// - BEAT_W         128          target response width; LINE_W % BEAT_W == 0
// - TGT_BASE       {40'h0,40'h100}  packed NUM_TGT*ADDR_W window bases
// - TGT_MASK       {40'h0,{40{1'b1}}<<16}  packed NUM_TGT*ADDR_W window masks
// - TIMEOUT_CYCLES 1024         WAIT cycles before error (>=1)
// PORTS
// - clk_i              in   1                clock
// - rstn_i             in   1                asynchronous reset, active low
// - req_valid_i        in   1                refill request
// - req_ready_o        out  1                router idle, request accepted when valid&ready
// - req_paddr_i        in   ADDR_W           line address
// - resp_valid_o       out  1                one-cycle response pulse (no backpressure)
// - resp_data_o        out  LINE_W           assembled line, beat 0 in LSBs
// - resp_error_o       out  1                unmapped address or timeout, qualified by resp_valid_o
// - busy_o             out  1                state != IDLE
// - tgt_req_valid_o    out  NUM_TGT          one-hot, one-cycle request pulse
// - tgt_req_paddr_o    out  ADDR_W           registered request address, shared by all targets
// - tgt_resp_valid_i   in   NUM_TGT          per-target beat valid
// - tgt_resp_data_i    in   NUM_TGT*BEAT_W   per-target beat data
// BEHAVIOUR
// - Reset values: all outputs 0, state IDLE, counters 0; req_ready_o=1 once out of reset.
// - Address decode: target i matches when (paddr & MASK[i]) == (BASE[i] & MASK[i]).
// - Lowest matching index wins. Decode is registered at acceptance.
// - FSM IDLE: req_ready_o=1. On accept at cycle T, latch paddr and target.
//   - Mapped -> ISSUE.
//   - Unmapped -> ERR.
// - FSM ISSUE (T+1): tgt_req_valid_o[sel]=1 for exactly one cycle, then -> WAIT.
// - FSM WAIT: each tgt_resp_valid_i[sel] beat is written at the beat counter slot; the counter increments.
//   - Beats from non-selected targets are ignored.
//   - A beat in the ISSUE cycle is accepted.
// - Last beat (count == LINE_W/BEAT_W-1) at cycle N -> RESP.
// - FSM RESP (N+1): resp_valid_o=1, resp_error_o=0, data held until the next response. Then -> IDLE.
// - FSM ERR (T+1): resp_valid_o=1, resp_error_o=1, resp_data_o=0. Then -> IDLE.
// - Watchdog: counts WAIT cycles and clears on every accepted beat.
//   - When it reaches TIMEOUT_CYCLES: resp_valid_o=1, resp_error_o=1, data=0, -> IDLE.
//   - Partial beats are discarded.
// - Beats arriving outside WAIT/ISSUE are dropped silently, so late beats after a timeout never corrupt later lines.
// - Minimum latency, accept to resp_valid_o:
//   - 2 cycles when the target answers with one beat in the ISSUE cycle.
//   - 1 cycle for an unmapped address.
// - Back-to-back: a new request is accepted in the IDLE cycle immediately after RESP or ERR.
// - Reset asserted mid-operation: immediate return to IDLE; no response is emitted, pending beats are lost.
// - resp_valid_o and tgt_req_valid_o are never asserted in the same cycle.
// CONFIGURATION
// - REFILL_ROUTER_STATS_EN defined adds three outputs:
//   - stat_req_cnt_o [31:0]: accepted requests.
//   - stat_timeout_cnt_o [31:0]: watchdog errors.
//   - stat_spurious_cnt_o [31:0]: dropped beats, including those from non-selected targets.
//   - All three saturate at 32'hFFFFFFFF, reset to 0, and update the cycle after the event.
// - Undefined: those ports and counters do not exist; functional behaviour is identical.
// TESTING
// - Target 0 returns 2 beats (A, B) for paddr 'h100 -> resp_data_o = {B,A}, resp_error_o=0, resp_valid_o one cycle.
// - paddr 'h0001_0000 -> target 1 pulsed, single-cycle ISSUE; same-cycle beat path (BEAT_W=LINE_W build) -> resp at T+2.
// - paddr matching no window -> resp_valid_o at T+1, resp_error_o=1, data 0, no tgt_req_valid_o pulse.
// - Target silent, TIMEOUT_CYCLES=16 -> error response 16 WAIT cycles after ISSUE; late beat then dropped.
//   - With REFILL_ROUTER_STATS_EN: stat_timeout_cnt_o=1, stat_spurious_cnt_o=1.
// - Non-selected target beat during WAIT -> ignored, line data unaffected.
// - rstn_i pulsed mid-WAIT -> outputs 0, IDLE, next request served normally.

Source files
------------

// File: rtl/fetch_refill_router_if.sv
// ---------------------------------------------------------------------------
// fetch_refill_router_if
// Bundles the fetch-side refill handshake and the per-target request/beat
// buses of fetch_refill_router into one interface.
//
// Modports
//   slave  : the router's view. It receives requests and target beats, and
//            drives the responses and target requests.
//   master : the harness view. It drives requests and target beats, and
//            receives the responses and target requests.
//
// Signals (direction as seen by the router)
//   req_valid_i       in   1               refill request
//   req_ready_o       out  1               router idle, accepted on valid&ready
//   req_paddr_i       in   ADDR_W          line address
//   resp_valid_o      out  1               one-cycle response pulse
//   resp_data_o       out  LINE_W          assembled line, beat 0 in LSBs
//   resp_error_o      out  1               unmapped / timeout, with resp_valid_o
//   busy_o            out  1               router not idle
//   tgt_req_valid_o   out  NUM_TGT         one-hot, one-cycle target request
//   tgt_req_paddr_o   out  ADDR_W          latched request address
//   tgt_resp_valid_i  in   NUM_TGT         per-target beat valid
//   tgt_resp_data_i   in   NUM_TGT*BEAT_W  per-target beat data
// ---------------------------------------------------------------------------
interface fetch_refill_router_if #(
  parameter int NUM_TGT = 2,
  parameter int ADDR_W  = 40,
  parameter int LINE_W  = 256,
  parameter int BEAT_W  = 128
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [ADDR_W-1:0]         req_paddr_i;
  logic                      resp_valid_o;
  logic [LINE_W-1:0]         resp_data_o;
  logic                      resp_error_o;
  logic                      busy_o;
  logic [NUM_TGT-1:0]        tgt_req_valid_o;
  logic [ADDR_W-1:0]         tgt_req_paddr_o;
  logic [NUM_TGT-1:0]        tgt_resp_valid_i;
  logic [NUM_TGT*BEAT_W-1:0] tgt_resp_data_i;

  modport slave (
    input  req_valid_i, req_paddr_i, tgt_resp_valid_i, tgt_resp_data_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_error_o, busy_o,
           tgt_req_valid_o, tgt_req_paddr_o
  );

  modport master (
    output req_valid_i, req_paddr_i, tgt_resp_valid_i, tgt_resp_data_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_error_o, busy_o,
           tgt_req_valid_o, tgt_req_paddr_o
  );
endinterface

// File: rtl/fetch_refill_router.sv
// ---------------------------------------------------------------------------
// fetch_refill_router
// Routes instruction-cache line refills to one of NUM_TGT backing responders.
// Each target owns an address window. The chosen target's beats are
// collected into a full line, and that line is returned to fetch as a
// one-cycle pulse. A watchdog turns a silent target into an error response.
//
// Ports
//   clk_i    in  clock
//   rstn_i   in  asynchronous reset, active low
//   bus      fetch_refill_router_if.slave (refill handshake + target buses)
//   stat_req_cnt_o      out 32  accepted requests      (REFILL_ROUTER_STATS_EN)
//   stat_timeout_cnt_o  out 32  watchdog errors        (REFILL_ROUTER_STATS_EN)
//   stat_spurious_cnt_o out 32  dropped target beats   (REFILL_ROUTER_STATS_EN)
//
// Configuration macro: REFILL_ROUTER_STATS_EN adds the saturating statistics
// counters. Without it, the router behaves identically but has no counters.
// ---------------------------------------------------------------------------
module fetch_refill_router #(
  parameter int                        NUM_TGT        = 2,
  parameter int                        ADDR_W         = 40,
  parameter int                        LINE_W         = 256,
  parameter int                        BEAT_W         = 128,
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE       = {40'h0, 40'h100},
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_MASK       = {40'h0, 40'hFF_FFFF_0000},
  parameter int                        TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  fetch_refill_router_if.slave bus
`ifdef REFILL_ROUTER_STATS_EN
  ,
  output logic [31:0]          stat_req_cnt_o,
  output logic [31:0]          stat_timeout_cnt_o,
  output logic [31:0]          stat_spurious_cnt_o
`endif
);

  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SEL_W  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_ready_en;
  logic [ADDR_W-1:0]   r_paddr;
  logic [SEL_W-1:0]    r_sel;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [WD_W-1:0]     r_wd;
  logic [LINE_W-1:0]   r_line;
  logic [LINE_W-1:0]   r_resp_data;
  logic [LINE_W-1:0]   w_line_next;

  logic [NUM_TGT-1:0]  w_match;
  logic [NUM_TGT-1:0]  w_sel_onehot;
  logic [NUM_TGT-1:0]  w_acc_mask;
  logic [BEAT_W-1:0]   w_tgt_data [NUM_TGT];
  logic [BEAT_W-1:0]   w_beat_data;
  logic                w_dec_hit;
  logic [SEL_W-1:0]    w_dec_sel;
  logic                w_accept;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_timeout;

  logic                w_req_ready;
  logic                w_resp_valid;
  logic                w_resp_error;
  logic                w_busy;
  logic [NUM_TGT-1:0]  w_tgt_req_valid;

  // -------------------------------------------------------------------------
  // Per-target window match, selected one-hot, and beat data slices
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_tgt
      assign w_match[gi] =
        ((bus.req_paddr_i & TGT_MASK[gi*ADDR_W +: ADDR_W]) ==
         (TGT_BASE[gi*ADDR_W +: ADDR_W] & TGT_MASK[gi*ADDR_W +: ADDR_W]));
      assign w_sel_onehot[gi] = (r_sel == SEL_W'(gi));
      assign w_tgt_data[gi]   = bus.tgt_resp_data_i[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  // Lowest matching index wins. The loop scans downward so that the last
  // assignment it makes comes from the smallest hit.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_sel = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_dec_hit = 1'b1;
        w_dec_sel = SEL_W'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Beat acceptance. Only the selected target is listened to, and only in
  // ISSUE or WAIT. Everything else is dropped, so a late beat after a
  // timeout cannot leak into the next line.
  // -------------------------------------------------------------------------
  assign w_acc_mask  = ((r_state == S_ISSUE) || (r_state == S_WAIT)) ? w_sel_onehot : '0;
  assign w_beat      = |(bus.tgt_resp_valid_i & w_acc_mask);
  assign w_beat_data = w_tgt_data[r_sel];
  assign w_last_beat = w_beat && (r_beat_cnt == CNT_W'(NBEATS - 1));
  // The watchdog fires on the TIMEOUT_CYCLES-th consecutive silent WAIT cycle.
  assign w_timeout   = (r_state == S_WAIT) && !w_beat &&
                       (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_accept    = bus.req_valid_i && w_req_ready;

  always_comb begin
    w_line_next = r_line;
    w_line_next[int'(r_beat_cnt)*BEAT_W +: BEAT_W] = w_beat_data;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_dec_hit ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE: begin
        w_state_next = w_last_beat ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (w_last_beat) begin
          w_state_next = S_RESP;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_req_ready     = 1'b0;
    w_resp_valid    = 1'b0;
    w_resp_error    = 1'b0;
    w_tgt_req_valid = '0;
    w_busy          = (r_state != S_IDLE);
    case (r_state)
      // r_ready_en keeps ready low until the first clock after reset release.
      S_IDLE:  w_req_ready     = r_ready_en;
      S_ISSUE: w_tgt_req_valid = w_sel_onehot;
      S_RESP:  w_resp_valid    = 1'b1;
      S_ERR: begin
        w_resp_valid = 1'b1;
        w_resp_error = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: request latch, beat assembly, watchdog, response line
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ready_en  <= 1'b0;
      r_paddr     <= '0;
      r_sel       <= '0;
      r_beat_cnt  <= '0;
      r_wd        <= '0;
      r_line      <= '0;
      r_resp_data <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_paddr    <= bus.req_paddr_i;
        r_sel      <= w_dec_sel;
        r_beat_cnt <= '0;
        r_wd       <= '0;
        r_line     <= '0;
      end
      if (w_beat) begin
        r_line     <= w_line_next;
        r_beat_cnt <= r_beat_cnt + 1'b1;
        r_wd       <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd <= r_wd + 1'b1;
      end
      // The response register holds the last line until the next response.
      // Error responses, whether unmapped or timed out, return zeros.
      if (w_last_beat) begin
        r_resp_data <= w_line_next;
      end else if (w_state_next == S_ERR) begin
        r_resp_data <= '0;
      end
    end
  end

  assign bus.req_ready_o     = w_req_ready;
  assign bus.resp_valid_o    = w_resp_valid;
  assign bus.resp_error_o    = w_resp_error;
  assign bus.resp_data_o     = r_resp_data;
  assign bus.busy_o          = w_busy;
  assign bus.tgt_req_valid_o = w_tgt_req_valid;
  assign bus.tgt_req_paddr_o = r_paddr;

  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
`ifdef REFILL_ROUTER_STATS_EN
  logic [NUM_TGT-1:0] w_drop_mask;
  logic [3:0]         w_drop_cnt;
  logic [31:0]        r_stat_req;
  logic [31:0]        r_stat_timeout;
  logic [31:0]        r_stat_spurious;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [3:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {29'b0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Several targets can deliver unwanted beats in the same cycle, so
  // every one of them is counted.
  assign w_drop_mask = bus.tgt_resp_valid_i & ~w_acc_mask;

  always_comb begin
    w_drop_cnt = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      w_drop_cnt = w_drop_cnt + {3'b0, w_drop_mask[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stat_req      <= '0;
      r_stat_timeout  <= '0;
      r_stat_spurious <= '0;
    end else begin
      r_stat_req      <= sat_add(r_stat_req, {3'b0, w_accept});
      r_stat_timeout  <= sat_add(r_stat_timeout, {3'b0, w_timeout});
      r_stat_spurious <= sat_add(r_stat_spurious, w_drop_cnt);
    end
  end

  assign stat_req_cnt_o      = r_stat_req;
  assign stat_timeout_cnt_o  = r_stat_timeout;
  assign stat_spurious_cnt_o = r_stat_spurious;
`else
  // Statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_refill_router.sv
// ---------------------------------------------------------------------------
// tb_fetch_refill_router
// Directed bench with a scoreboard. The stimulus pushes expected line
// responses and expected target pulses into queues. Monitors on the falling
// edge pop those queues and compare whenever the router presents an output.
// Window map: target 0 covers 0x0_0000-0x0_FFFF and target 1 covers
// 0x1_0000-0x1_FFFF. Every other address is unmapped. The watchdog is 16.
// ---------------------------------------------------------------------------
module tb_fetch_refill_router;
  localparam int NUM_TGT = 2;
  localparam int ADDR_W  = 40;
  localparam int LINE_W  = 256;
  localparam int BEAT_W  = 128;
  localparam int TO      = 16;
  localparam logic [NUM_TGT*ADDR_W-1:0] BASE = {40'h00_0001_0000, 40'h00_0000_0000};
  localparam logic [NUM_TGT*ADDR_W-1:0] MASK = {40'hFF_FFFF_0000, 40'hFF_FFFF_0000};

  localparam logic [BEAT_W-1:0] BA = 128'hA000_0000_0000_0001_A000_0000_0000_0002;
  localparam logic [BEAT_W-1:0] BB = 128'hB000_0000_0000_0003_B000_0000_0000_0004;
  localparam logic [BEAT_W-1:0] BC = 128'hC0C0_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [BEAT_W-1:0] BD = 128'hD0D0_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [BEAT_W-1:0] BE = 128'hE1E1_0000_0000_0000_0000_0000_0000_00E1;
  localparam logic [BEAT_W-1:0] BF = 128'hF1F1_0000_0000_0000_0000_0000_0000_00F1;
  localparam logic [BEAT_W-1:0] BJ = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [BEAT_W-1:0] BG = 128'h6060_6060_6060_6060_6060_6060_6060_6060;
  localparam logic [BEAT_W-1:0] BH = 128'h7070_7070_7070_7070_7070_7070_7070_7070;
  localparam logic [BEAT_W-1:0] BI = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [BEAT_W-1:0] BK = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fetch_refill_router_if #(.NUM_TGT(NUM_TGT), .ADDR_W(ADDR_W), .LINE_W(LINE_W),
                           .BEAT_W(BEAT_W)) bus ();

`ifdef REFILL_ROUTER_STATS_EN
  logic [31:0] s_req, s_to, s_sp;
`endif

  fetch_refill_router #(
    .NUM_TGT(NUM_TGT), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W),
    .TGT_BASE(BASE), .TGT_MASK(MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
`ifdef REFILL_ROUTER_STATS_EN
    ,
    .stat_req_cnt_o      (s_req),
    .stat_timeout_cnt_o  (s_to),
    .stat_spurious_cnt_o (s_sp)
`endif
  );

  typedef struct {
    logic [LINE_W-1:0] data;
    logic              err;
    int                acc;
    int                lat;
  } resp_t;

  typedef struct {
    logic [NUM_TGT-1:0] oh;
    logic [ADDR_W-1:0]  paddr;
    int                 acc;
  } treq_t;

  resp_t rq[$];
  treq_t tq[$];
  resp_t m_e;
  treq_t m_t;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response and target-request monitors
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.resp_valid_o || (bus.tgt_req_valid_o != '0))
        chk_int("resp_tgt_exclusive",
                int'(bus.resp_valid_o && (bus.tgt_req_valid_o != '0)), 0);
      if (bus.resp_valid_o) begin
        if (rq.size() == 0) begin
          chk_int("unexpected_resp", 1, 0);
        end else begin
          m_e = rq.pop_front();
          $display("[TB] resp cyc=%0d err=%0b data=%0h", cyc, bus.resp_error_o, bus.resp_data_o);
          chk_line("resp_data", bus.resp_data_o, m_e.data);
          chk_int("resp_error", int'(bus.resp_error_o), int'(m_e.err));
          chk_int("resp_latency", cyc - m_e.acc, m_e.lat);
        end
      end
      if (bus.tgt_req_valid_o != '0) begin
        if (tq.size() == 0) begin
          chk_int("unexpected_tgt_req", int'(bus.tgt_req_valid_o), 0);
        end else begin
          m_t = tq.pop_front();
          $display("[TB] tgt_req cyc=%0d oh=%b paddr=%0h", cyc, bus.tgt_req_valid_o,
                   bus.tgt_req_paddr_o);
          chk_int("tgt_req_onehot", int'(bus.tgt_req_valid_o), int'(m_t.oh));
          chk_line("tgt_req_paddr", LINE_W'(bus.tgt_req_paddr_o), LINE_W'(m_t.paddr));
          chk_int("tgt_req_latency", cyc - m_t.acc, 1);
        end
      end
    end
  end

  // Issue one request at the next idle falling edge. The task returns at the
  // falling edge of the cycle after acceptance.
  task automatic send(input logic [ADDR_W-1:0] pa, input logic [LINE_W-1:0] d,
                      input logic err, input int lat, input logic [NUM_TGT-1:0] oh,
                      output int acc);
    resp_t r;
    treq_t t;
    for (int i = 0; i < 50 && !bus.req_ready_o; i++) @(negedge clk);
    acc = cyc;
    if (!bus.req_ready_o) begin
      chk_int("req_ready_wait", 0, 1);
      return;
    end
    bus.req_valid_i = 1'b1;
    bus.req_paddr_i = pa;
    r.data = d; r.err = err; r.acc = acc; r.lat = lat;
    rq.push_back(r);
    if (oh != '0) begin
      t.oh = oh; t.paddr = pa; t.acc = acc;
      tq.push_back(t);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic beat(input int tgt, input logic [BEAT_W-1:0] d);
    bus.tgt_resp_valid_i = NUM_TGT'(1) << tgt;
    bus.tgt_resp_data_i[tgt*BEAT_W +: BEAT_W] = d;
    @(negedge clk);
    bus.tgt_resp_valid_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_int({tag, "_ready"}, int'(bus.req_ready_o), 0);
    chk_int({tag, "_resp_valid"}, int'(bus.resp_valid_o), 0);
    chk_int({tag, "_resp_error"}, int'(bus.resp_error_o), 0);
    chk_int({tag, "_busy"}, int'(bus.busy_o), 0);
    chk_int({tag, "_tgt_valid"}, int'(bus.tgt_req_valid_o), 0);
    chk_line({tag, "_resp_data"}, bus.resp_data_o, '0);
    chk_line({tag, "_tgt_paddr"}, LINE_W'(bus.tgt_req_paddr_o), '0);
  endtask

  initial begin
    int t1, t2;
    bus.req_valid_i      = 1'b0;
    bus.req_paddr_i      = '0;
    bus.tgt_resp_valid_i = '0;
    bus.tgt_resp_data_i  = '0;
    idle(3);
    check_reset_outputs("reset");
    rstn = 1'b1;
    idle(2);
    chk_int("ready_after_reset", int'(bus.req_ready_o), 1);
    chk_int("busy_after_reset", int'(bus.busy_o), 0);

    // Target 0 with two beats in WAIT returns {B,A}. The response arrives at T+4.
    send(40'h100, {BB, BA}, 1'b0, 4, 2'b01, t1);
    idle(1);
    beat(0, BA);
    beat(0, BB);

    // Target 1 with its first beat in the ISSUE cycle. The response arrives at T+3.
    send(40'h1_0040, {BD, BC}, 1'b0, 3, 2'b10, t1);
    beat(1, BC);
    beat(1, BD);

    // Unmapped address: error at T+1 and no target pulse. Then back-to-back.
    send(40'h2_0000, '0, 1'b1, 1, 2'b00, t1);
    send(40'h3_0000, '0, 1'b1, 1, 2'b00, t2);
    chk_int("b2b_accept_gap", t2 - t1, 2);

    // Non-selected target beat during WAIT must be ignored.
    send(40'h200, {BF, BE}, 1'b0, 5, 2'b01, t1);
    idle(1);
    beat(0, BE);
    beat(1, BJ);
    beat(0, BF);

    // Silent target: ISSUE at T+1, 16 WAIT cycles, then the error at T+18.
    send(40'h1_8000, '0, 1'b1, 18, 2'b10, t1);
    idle(17);
    idle(1);
    beat(1, BJ);
    idle(2);
`ifdef REFILL_ROUTER_STATS_EN
    chk_int("stat_req", int'(s_req), 6);
    chk_int("stat_timeout", int'(s_to), 1);
    chk_int("stat_spurious", int'(s_sp), 2);
`endif

    // The next line must come out clean after the late beat.
    send(40'h400, {BH, BG}, 1'b0, 4, 2'b01, t1);
    idle(1);
    beat(0, BG);
    beat(0, BH);

    // Reset asserted mid-WAIT: outputs clear and no response is emitted.
    send(40'h500, {BK, BK}, 1'b0, 4, 2'b01, t1);
    idle(1);
    beat(0, BK);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk_int("midreset_pending", rq.size(), 1);
    if (rq.size() > 0) void'(rq.pop_back());
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    chk_int("ready_after_midreset", int'(bus.req_ready_o), 1);

    send(40'h1_0100, {BK, BI}, 1'b0, 3, 2'b10, t1);
    beat(1, BI);
    beat(1, BK);

    for (int i = 0; i < 50 && (rq.size() != 0 || tq.size() != 0); i++) @(negedge clk);
    idle(2);
    chk_int("resp_queue_empty", rq.size(), 0);
    chk_int("tgt_queue_empty", tq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "bench time limit reached");
  end

endmodule
